hier_fanin_collector: RTL and testbench

Fan-in collector for one node of the generated instance hierarchy. Each parent node instantiates five children; this block is the return path that carries traffic from those five children up to the parent. It accepts tagged words from five child valid/ready streams, arbitrates round-robin, and presents one registered upstream stream carrying the data and the source child index.

---
 rtl/hier_fanin_pkg.sv | 8 +
 rtl/hier_rr_arb5.sv | 27 ++
 rtl/hier_fanin_collector.sv | 77 +++++++
 tb/tb_hier_fanin_collector.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hier_fanin_pkg.sv
// hier_fanin_pkg: shared child index type, child count and modulo-5 increment
package hier_fanin_pkg;
    localparam int N_CHILD = 5;
    typedef logic [2:0] child_idx_t;
    function automatic child_idx_t next_idx(input child_idx_t i);
        return (i == 3'd4) ? 3'd0 : i + 3'd1;
    endfunction
endpackage

// File: rtl/hier_rr_arb5.sv
// hier_rr_arb5: combinational five-way round-robin arbiter searching upward from ptr
module hier_rr_arb5
    import hier_fanin_pkg::*;
(
    input  logic [4:0] req,
    input  child_idx_t ptr,
    input  logic       en,
    output logic [4:0] gnt,
    output child_idx_t gidx,
    output logic       any
);
    // first requester at or after ptr, wrapping 4 -> 0; grant only when enabled
    always_comb begin
        child_idx_t v;
        any  = 1'b0;
        gidx = 3'd0;
        v    = ptr;
        for (int k = 0; k < 5; k++) begin
            if (!any && req[v]) begin
                any  = 1'b1;
                gidx = v;
            end
            v = next_idx(v);
        end
        gnt = (en && any) ? 5'(5'b00001 << gidx) : 5'b00000;
    end
endmodule

// File: rtl/hier_fanin_collector.sv
// hier_fanin_collector: round-robin fan-in of five child streams into one registered upstream stream; HIER_FANIN_PARITY_EN adds up_par
module hier_fanin_collector #(
    parameter int DATA_W  = 16,
    parameter int N_CHILD = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_CHILD-1:0]        ch_valid,
    input  logic [N_CHILD*DATA_W-1:0] ch_data,
    output logic [N_CHILD-1:0]        ch_ready,
    output logic                      up_valid,
    output logic [DATA_W-1:0]         up_data,
    output logic [2:0]                up_src,
    input  logic                      up_ready
`ifdef HIER_FANIN_PARITY_EN
    ,
    output logic                      up_par
`endif
);
    import hier_fanin_pkg::*;

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    child_idx_t        r_src;
    child_idx_t        r_ptr;
    logic              w_load;
    logic              w_xfer;
    logic [4:0]        w_gnt;
    child_idx_t        w_gidx;
    logic              w_any;
    logic [DATA_W-1:0] w_data;

    assign w_load = !r_valid || up_ready;
    assign w_xfer = w_any && w_load;
    assign w_data = ch_data[w_gidx*DATA_W +: DATA_W];

    hier_rr_arb5 u_arb (
        .req  (ch_valid),
        .ptr  (r_ptr),
        .en   (w_load && rst_n),
        .gnt  (w_gnt),
        .gidx (w_gidx),
        .any  (w_any)
    );

    // output register: load on child transfer, empty on drain, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_src   <= 3'd0;
            r_ptr   <= 3'd0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_data;
            r_src   <= w_gidx;
            r_ptr   <= next_idx(w_gidx);
        end else if (up_ready) begin
            r_valid <= 1'b0;
        end
    end

`ifdef HIER_FANIN_PARITY_EN
    logic r_par;
    // parity captured with the word so it stays stable through a stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_par <= 1'b0;
        else if (w_xfer) r_par <= ^{w_gidx, w_data};
    end
    assign up_par = r_par;
`endif

    assign ch_ready = w_gnt;
    assign up_valid = r_valid;
    assign up_data  = r_data;
    assign up_src   = r_src;
endmodule

// File: tb/tb_hier_fanin_collector.sv
// tb_hier_fanin_collector: scoreboard bench for hier_fanin_collector (HIER_FANIN_PARITY_EN enables the parity test)
module tb_hier_fanin_collector;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  ch_valid = '0;
    logic [79:0] ch_data = '0;
    logic [4:0]  ch_ready;
    logic        up_valid;
    logic [15:0] up_data;
    logic [2:0]  up_src;
    logic        up_ready = 1'b0;
`ifdef HIER_FANIN_PARITY_EN
    logic        up_par;
`endif

    int checks = 0;
    int passes = 0;
    logic [18:0] sb[$];

    hier_fanin_collector dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ch_valid (ch_valid),
        .ch_data  (ch_data),
        .ch_ready (ch_ready),
        .up_valid (up_valid),
        .up_data  (up_data),
        .up_src   (up_src),
        .up_ready (up_ready)
`ifdef HIER_FANIN_PARITY_EN
        ,
        .up_par   (up_par)
`endif
    );

    always #5 clk = ~clk;

    // scoreboard: every upstream transfer must match the oldest expected word
    always @(negedge clk) begin
        if (rst_n && up_valid && up_ready) begin
            logic [18:0] e;
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected got src=%0d data=%h, expected no word", up_src, up_data);
            end else begin
                e = sb.pop_front();
                if ({up_src, up_data} !== e)
                    $display("FAIL sb_word got src=%0d data=%h, expected src=%0d data=%h", up_src, up_data, e[18:16], e[15:0]);
                else
                    passes++;
`ifdef HIER_FANIN_PARITY_EN
                checks++;
                if (up_par !== ^e)
                    $display("FAIL sb_par got %b, expected %b", up_par, ^e);
                else
                    passes++;
`endif
            end
        end
    end

    task automatic set_data(input int i, input logic [15:0] v);
        ch_data[i*16 +: 16] = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ready(input string name, input logic [4:0] exp);
        @(negedge clk);
        checks++;
        if (ch_ready !== exp) $display("FAIL %s ch_ready got %b, expected %b", name, ch_ready, exp);
        else passes++;
    endtask

    task automatic do_reset();
        ch_valid = '0;
        up_ready = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ch_valid = 5'($urandom_range(1, 31));
            up_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (up_valid !== 1'b0 || up_src !== 3'd0 || up_data !== 16'h0 || ch_ready !== 5'b0)
                $display("FAIL reset_state got v=%b src=%0d data=%h rdy=%b, expected 0 0 0000 00000", up_valid, up_src, up_data, ch_ready);
            else passes++;
            step();
        end
        ch_valid = '0;
        rst_n = 1'b1;
        step();
        step();
        @(negedge clk);
        checks++;
        if (up_valid !== 1'b0 || up_src !== 3'd0 || ch_ready !== 5'b0)
            $display("FAIL reset_release got v=%b src=%0d rdy=%b, expected 0 0 00000", up_valid, up_src, ch_ready);
        else passes++;
    endtask

    task automatic test_single();
        do_reset();
        up_ready = 1'b1;
        set_data(3, 16'h00A5);
        ch_valid = 5'b01000;
        sb.push_back({3'd3, 16'h00A5});
        chk_ready("single_grant", 5'b01000);
        step();
        ch_valid = '0;
        @(negedge clk);
        checks++;
        if (up_valid !== 1'b1 || up_data !== 16'h00A5 || up_src !== 3'd3 || ch_ready !== 5'b0)
            $display("FAIL single_out got v=%b data=%h src=%0d rdy=%b, expected 1 00a5 3 00000", up_valid, up_data, up_src, ch_ready);
        else passes++;
        step();
        @(negedge clk);
        checks++;
        if (up_valid !== 1'b0) $display("FAIL single_empty up_valid got %b, expected 0", up_valid);
        else passes++;
    endtask

    task automatic test_fairness();
        do_reset();
        up_ready = 1'b1;
        for (int i = 0; i < 5; i++) set_data(i, 16'h1000 + 16'(i));
        ch_valid = 5'b11111;
        for (int k = 0; k < 10; k++) sb.push_back({3'(k % 5), 16'h1000 + 16'(k % 5)});
        for (int k = 0; k < 10; k++) begin
            chk_ready("fair_grant", 5'(5'b00001 << (k % 5)));
            if (k > 0) begin
                checks++;
                if (up_valid !== 1'b1) $display("FAIL fair_rate up_valid got %b, expected 1", up_valid);
                else passes++;
            end
            step();
        end
        ch_valid = '0;
        step();
        step();
    endtask

    task automatic test_back_to_back_stall();
        do_reset();
        set_data(1, 16'h0111);
        set_data(2, 16'h0222);
        set_data(4, 16'h0444);
        ch_valid = 5'b00010;
        sb.push_back({3'd1, 16'h0111});
        chk_ready("bp_first", 5'b00010);
        step();
        ch_valid = 5'b10100;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (up_valid !== 1'b1 || up_data !== 16'h0111 || up_src !== 3'd1 || ch_ready !== 5'b0)
                $display("FAIL bp_stall got v=%b data=%h src=%0d rdy=%b, expected 1 0111 1 00000", up_valid, up_data, up_src, ch_ready);
            else passes++;
            step();
        end
        up_ready = 1'b1;
        sb.push_back({3'd2, 16'h0222});
        sb.push_back({3'd4, 16'h0444});
        chk_ready("bp_next2", 5'b00100);
        step();
        ch_valid = 5'b10000;
        chk_ready("bp_next4", 5'b10000);
        step();
        ch_valid = '0;
        step();
        step();
    endtask

    task automatic test_wrap_hold();
        do_reset();
        up_ready = 1'b1;
        set_data(3, 16'h0333);
        ch_valid = 5'b01000;
        sb.push_back({3'd3, 16'h0333});
        chk_ready("wrap_setptr", 5'b01000);
        step();
        set_data(0, 16'h0A00);
        set_data(4, 16'h0A04);
        ch_valid = 5'b10001;
        sb.push_back({3'd4, 16'h0A04});
        sb.push_back({3'd0, 16'h0A00});
        chk_ready("wrap_g4", 5'b10000);
        step();
        ch_valid = 5'b00001;
        chk_ready("wrap_g0", 5'b00001);
        step();
        ch_valid = '0;
        for (int k = 0; k < 3; k++) begin
            chk_ready("hold_idle", 5'b00000);
            step();
        end
        set_data(0, 16'h0B00);
        set_data(1, 16'h0B01);
        ch_valid = 5'b00011;
        sb.push_back({3'd1, 16'h0B01});
        sb.push_back({3'd0, 16'h0B00});
        chk_ready("hold_g1", 5'b00010);
        step();
        ch_valid = 5'b00001;
        chk_ready("hold_g0", 5'b00001);
        step();
        ch_valid = '0;
        step();
        step();
    endtask

    task automatic test_reset_midstream();
        do_reset();
        set_data(2, 16'h5A5A);
        ch_valid = 5'b00100;
        step();
        ch_valid = '0;
        @(negedge clk);
        checks++;
        if (up_valid !== 1'b1 || up_data !== 16'h5A5A)
            $display("FAIL mid_loaded got v=%b data=%h, expected 1 5a5a", up_valid, up_data);
        else passes++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (up_valid !== 1'b0 || up_data !== 16'h0 || up_src !== 3'd0)
            $display("FAIL mid_async got v=%b data=%h src=%0d, expected 0 0000 0", up_valid, up_data, up_src);
        else passes++;
        step();
        rst_n = 1'b1;
        step();
    endtask

`ifdef HIER_FANIN_PARITY_EN
    task automatic test_parity();
        do_reset();
        up_ready = 1'b1;
        set_data(2, 16'h0001);
        ch_valid = 5'b00100;
        sb.push_back({3'd2, 16'h0001});
        step();
        set_data(1, 16'h0000);
        ch_valid = 5'b00010;
        sb.push_back({3'd1, 16'h0000});
        @(negedge clk);
        checks++;
        if (up_par !== 1'b0) $display("FAIL par_c2 got %b, expected 0", up_par);
        else passes++;
        step();
        ch_valid = '0;
        @(negedge clk);
        checks++;
        if (up_par !== 1'b1) $display("FAIL par_c1 got %b, expected 1", up_par);
        else passes++;
        step();
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_back_to_back_stall();
        test_wrap_hold();
        test_reset_midstream();
`ifdef HIER_FANIN_PARITY_EN
        test_parity();
`endif
        step();
        checks++;
        if (sb.size() != 0) $display("FAIL sb_drain got %0d words left, expected 0", sb.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
